mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle sequencer for MIPS MULT/DIV, driven by the main control unit.
- Accepts a start pulse plus two register operands (A/B latched outputs) and iterates a shift-add multiplier or a restoring divider over WIDTH cycles.
- Commits the result to internal HI/LO registers and pulses done.
- Control unit stalls in its own state while busy=1.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV.
- a  in  WIDTH  operand rs: multiplicand or dividend.
- b  in  WIDTH  operand rt: multiplier or divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  sticky; set by DIV with b=0, cleared by the next accepted start.
- hi  out  WIDTH  MULT: upper product; DIV: remainder.
- lo  out  WIDTH  MULT: lower product; DIV: quotient.

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE.
  - busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
  - An operation in flight is aborted and no partial result is committed.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - start=1 latches |a|, |b| (two's-complement magnitude), the result sign (a^b MSB), the remainder sign (a MSB) and op.
  - Clears div_zero and counter.
  - Next state is MULT, or DIV, or DONE directly if op=1 and b=0.
- MULT: one iteration per cycle.
  - If multiplier LSB=1, add multiplicand into the upper half of the 2*WIDTH accumulator (WIDTH+1-bit add, keep carry).
  - Shift the accumulator right by 1.
  - After WIDTH iterations (counter==WIDTH-1), go to FIX.
- DIV: restoring division, one iteration per cycle.
  - Shift {rem,quot} left by 1.
  - Trial-subtract the divisor from rem on a WIDTH+1-bit subtraction.
  - If non-negative: keep the difference and set quot LSB=1.
  - After WIDTH iterations, go to FIX.
- FIX:
  - Apply sign correction: product negated as 2*WIDTH if the result sign is set; quotient negated if the result sign is set; remainder negated if the dividend was negative.
  - Write hi/lo; go to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - Return to IDLE.
  - A start in DONE is ignored; it must be reissued in IDLE.
- Latency: start accepted at edge N; done high during cycle N+WIDTH+2 (34 for WIDTH=32).
- Divide by zero:
  - done is high in the cycle after acceptance.
  - div_zero=1; hi/lo keep their previous values.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF:
  - Result wraps: lo=0x80000000, hi=0.
  - No flag is raised.
- start while busy: ignored; operands and op are not re-latched.
- a and b may change after acceptance without affecting the result.
- hi/lo change only in FIX and on reset.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When 1, the magnitude conversion and FIX negation are bypassed (MULTU/DIVU).
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Shared package mult_div_pkg holds:
  - the state encoding constants (IDLE=0, MULT=1, DIV=2, FIX=3, DONE=4, 3-bit);
  - the op constants OP_MULT=0, OP_DIV=1;
  - the MIPS funct codes MULT=6'h18, DIV=6'h1A for the control unit decoder.
- Sub-module: mult_div_datapath, containing the accumulator/remainder registers, the add/subtract and the negation logic.
- The top level keeps the FSM and counter.

Test Plan:
- MULT a=7, b=6 -> done at cycle 34 after start; hi=0, lo=42; busy high for cycles 1..33.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- DIV a=100, b=0 (hi/lo previously 1/42) -> done one cycle after acceptance; div_zero=1; hi=1, lo=42 unchanged. The next MULT start clears div_zero.
- MULT 3x4 started, reset=0 at cycle 10 -> busy=0, hi=lo=0, no done. A fresh MULT 3x4 afterwards gives lo=12.
- start pulsed again at cycle 5 of DIV 9/2 with a=1, b=1 -> ignored; result lo=4, hi=1. With MULT_DIV_UNSIGNED_EN, MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the MIPS MULT/DIV sequencer and its control-unit decoder.
package mult_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // MIPS funct field values used by the main control unit decoder.
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_datapath.sv
// Datapath for the MULT/DIV sequencer: operand magnitudes, the shared
// 2*WIDTH accumulator ({rem,quot} in divide mode), iteration add/subtract,
// sign correction and the architectural HI/LO registers.
module mult_div_datapath
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step_mult,
  input  logic             step_div,
  input  logic             fix,
  input  logic             fix_div,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               res_neg;
  logic               rem_neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_mult;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes, one multiply/divide iteration and the final sign correction.
  always_comb begin
    a_mag = (a[WIDTH-1] && !is_unsigned) ? -a : a;
    b_mag = (b[WIDTH-1] && !is_unsigned) ? -b : b;

    mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_mult = {mult_sum, acc[WIDTH-1:1]};

    // rem_sh keeps the bit shifted out of rem so the trial subtract is WIDTH+1 wide.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, mcand};
    acc_div  = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix = res_neg ? -acc : acc;
    quot_fix = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Operand latch, iteration register and HI/LO commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (load) begin
      res_neg <= !is_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
      rem_neg <= !is_unsigned && a[WIDTH-1];
      if (op == OP_DIV) begin
        acc   <= {{WIDTH{1'b0}}, a_mag};
        mcand <= b_mag;
      end else begin
        acc   <= {{WIDTH{1'b0}}, b_mag};
        mcand <= a_mag;
      end
    end else if (step_mult) begin
      acc <= acc_mult;
    end else if (step_div) begin
      acc <= acc_div;
    end else if (fix) begin
      if (fix_div) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS MULT/DIV multicycle sequencer: FSM and iteration counter around
// mult_div_datapath. Optional MULT_DIV_UNSIGNED_EN adds the is_unsigned
// input (MULTU/DIVU); without it every operation is signed.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             op_q;
  logic             accept;
  logic             step_mult;
  logic             step_div;
  logic             fix;
  logic             unsigned_sel;

`ifdef MULT_DIV_UNSIGNED_EN
  assign unsigned_sel = is_unsigned;
`else
  assign unsigned_sel = 1'b0;
`endif

  // State, counter, latched op and sticky divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MULT;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        op_q     <= op;
        div_zero <= (op == OP_DIV) && (b == '0);
      end
    end
  end

  // Next-state, counter update and decoded status/datapath controls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    step_mult  = 1'b0;
    step_div   = 1'b0;
    fix        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          cnt_next = '0;
          if (op == OP_DIV && b == '0) state_next = ST_DONE;
          else if (op == OP_DIV)       state_next = ST_DIV;
          else                         state_next = ST_MULT;
        end
      end
      ST_MULT, ST_DIV: begin
        busy      = 1'b1;
        step_mult = (state == ST_MULT);
        step_div  = (state == ST_DIV);
        cnt_next  = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        fix        = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mult_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .op         (op),
    .is_unsigned(unsigned_sel),
    .a          (a),
    .b          (b),
    .step_mult  (step_mult),
    .step_div   (step_div),
    .fix        (fix),
    .fix_div    (op_q),
    .hi         (hi),
    .lo         (lo)
  );

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULT_DIV_UNSIGNED_EN
  logic         is_unsigned;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
`ifdef MULT_DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an operation so it is accepted at the next rising edge, then
  // scramble the inputs to show they are not needed after acceptance.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts cycles after acceptance until done; busy must be high before it and low with it.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    logic bok;
    int   dcnt;

    reset = 1'b0;
    start = 1'b0;
    op    = OP_MULT;
    a     = '0;
    b     = '0;
`ifdef MULT_DIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hilo", {hi, lo}, 64'h0);
    reset = 1'b1;

    // MULT 7 x 6
    issue(OP_MULT, 32'd7, 32'd6);
    wait_done(lat, bok);
    check("mul7x6_lat", lat, 34);
    check("mul7x6_busy", bok, 1);
    check("mul7x6_hilo", {hi, lo}, 64'd42);

    // DONE-cycle start is ignored
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd5;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("done_start_busy", busy, 0);
    @(negedge clk);
    check("done_start_idle", {busy, done}, 2'b00);
    check("done_start_hilo", {hi, lo}, 64'd42);

    // MULT -3 x 5
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bok);
    check("mul_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // MULT with carry out of the upper half
    issue(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(lat, bok);
    check("mul_big_hilo", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

    // MULT -5 x -5
    issue(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    wait_done(lat, bok);
    check("mul_nn_hilo", {hi, lo}, 64'd25);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bok);
    check("div_neg_lat", lat, 34);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_neg_dz", div_zero, 0);

    // DIV overflow wraps silently
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("div_ovf_dz", div_zero, 0);

    // DIV 169 / 4 sets hi=1, lo=42
    issue(OP_DIV, 32'd169, 32'd4);
    wait_done(lat, bok);
    check("div169_hilo", {hi, lo}, {32'd1, 32'd42});

    // DIV by zero
    issue(OP_DIV, 32'd100, 32'd0);
    check("dz_flag_set", div_zero, 1);
    wait_done(lat, bok);
    check("dz_lat", lat, 1);
    check("dz_busy", bok, 1);
    check("dz_hilo", {hi, lo}, {32'd1, 32'd42});
    repeat (3) @(negedge clk);
    check("dz_sticky", div_zero, 1);

    // MULT 3 x 4 aborted by reset mid-flight
    issue(OP_MULT, 32'd3, 32'd4);
    check("dz_cleared", div_zero, 0);
    repeat (9) @(negedge clk);
    check("abort_busy_pre", busy, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hilo", {hi, lo}, 64'h0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_quiet", dcnt, 0);
    check("abort_hilo_hold", {hi, lo}, 64'h0);

    issue(OP_MULT, 32'd3, 32'd4);
    wait_done(lat, bok);
    check("mul3x4_lat", lat, 34);
    check("mul3x4_hilo", {hi, lo}, 64'd12);

    // DIV 9 / 2 with a second start while busy
    issue(OP_DIV, 32'd9, 32'd2);
    repeat (4) @(negedge clk);
    op    = OP_MULT;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    check("restart_lat", lat, 30);
    check("restart_hilo", {hi, lo}, {32'd1, 32'd4});

`ifdef MULT_DIV_UNSIGNED_EN
    is_unsigned = 1'b1;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    is_unsigned = 1'b0;
    wait_done(lat, bok);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    is_unsigned = 1'b1;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    is_unsigned = 1'b0;
    wait_done(lat, bok);
    check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`else
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, bok);
    check("mul_m1x2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
